// File: rtl/rv_csr_access_unit_if.sv
// rv_csr_access_unit_if: dispatch request, CSR data block, FPU status and
// writeback response signals of the CSR access unit.
// slave = the access unit, master = its surroundings.

`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif

interface rv_csr_access_unit_if;
    // dispatch request
    logic                          req_valid;
    logic                          req_ready;
    logic [`UUID_BITS-1:0]         req_uuid;
    logic [`NW_BITS-1:0]           req_wid;
    logic [`NUM_THREADS-1:0]       req_tmask;
    logic [31:0]                   req_pc;
    logic [1:0]                    req_op;
    logic                          req_use_imm;
    logic [4:0]                    req_imm;
    logic [31:0]                   req_rs1_data;
    logic                          req_rs1_zero;
    logic [`CSR_ADDR_BITS-1:0]     req_addr;
    logic [4:0]                    req_rd;
    logic                          req_wb;
    // per-warp FPU in-flight flags
    logic [`NUM_WARPS-1:0]         fpu_pending;
    // CSR data block read/write ports
    logic                          csr_read_enable;
    logic [`UUID_BITS-1:0]         csr_read_uuid;
    logic [`CSR_ADDR_BITS-1:0]     csr_read_addr;
    logic [`NW_BITS-1:0]           csr_read_wid;
    logic [31:0]                   csr_read_data;
    logic                          csr_write_enable;
    logic [`UUID_BITS-1:0]         csr_write_uuid;
    logic [`CSR_ADDR_BITS-1:0]     csr_write_addr;
    logic [`NW_BITS-1:0]           csr_write_wid;
    logic [31:0]                   csr_write_data;
    logic                          csr_busy;
    // writeback response
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [`UUID_BITS-1:0]         rsp_uuid;
    logic [`NW_BITS-1:0]           rsp_wid;
    logic [`NUM_THREADS-1:0]       rsp_tmask;
    logic [31:0]                   rsp_pc;
    logic [4:0]                    rsp_rd;
    logic                          rsp_wb;
    logic [`NUM_THREADS*32-1:0]    rsp_data;

    modport slave (
        input  req_valid, req_uuid, req_wid, req_tmask, req_pc, req_op,
               req_use_imm, req_imm, req_rs1_data, req_rs1_zero, req_addr,
               req_rd, req_wb, fpu_pending, csr_read_data, rsp_ready,
        output req_ready, csr_read_enable, csr_read_uuid, csr_read_addr,
               csr_read_wid, csr_write_enable, csr_write_uuid, csr_write_addr,
               csr_write_wid, csr_write_data, csr_busy, rsp_valid, rsp_uuid,
               rsp_wid, rsp_tmask, rsp_pc, rsp_rd, rsp_wb, rsp_data
    );

    modport master (
        output req_valid, req_uuid, req_wid, req_tmask, req_pc, req_op,
               req_use_imm, req_imm, req_rs1_data, req_rs1_zero, req_addr,
               req_rd, req_wb, fpu_pending, csr_read_data, rsp_ready,
        input  req_ready, csr_read_enable, csr_read_uuid, csr_read_addr,
               csr_read_wid, csr_write_enable, csr_write_uuid, csr_write_addr,
               csr_write_wid, csr_write_data, csr_busy, rsp_valid, rsp_uuid,
               rsp_wid, rsp_tmask, rsp_pc, rsp_rd, rsp_wb, rsp_data
    );
endinterface

// File: rtl/rv_csr_access_unit.sv
// rv_csr_access_unit: accepts one CSR instruction at a time, waits out FPU
// ops in flight for FP CSRs, performs a one-cycle read-modify-write on the
// CSR data block and returns the old value (broadcast per thread).
// Optional macro CSR_RO_GUARD_EN: suppress the write strobe for CSR
// addresses in read-only space (addr[11:10] == 2'b11).

`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef CSR_FFLAGS
`define CSR_FFLAGS 12'h001
`endif
`ifndef CSR_FRM
`define CSR_FRM 12'h002
`endif
`ifndef CSR_FCSR
`define CSR_FCSR 12'h003
`endif

module rv_csr_access_unit #(
    parameter int unsigned CORE_ID = 0
) (
    input  logic                clk,
    input  logic                reset,
    rv_csr_access_unit_if.slave bus
);

    localparam int unsigned UUID_W = `UUID_BITS;
    localparam int unsigned NW_W   = `NW_BITS;
    localparam int unsigned NT     = `NUM_THREADS;
    localparam int unsigned ADDR_W = `CSR_ADDR_BITS;

    // CORE_ID only tags debug output; keep it within an 8-bit tag.
    if (CORE_ID > 32'd255) begin : g_core_id_range
        $error("rv_csr_access_unit: CORE_ID exceeds 8-bit debug tag");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RSP    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_busy;
    logic                r_csr_read_enable;
    logic                r_csr_write_enable;
    logic                r_rsp_valid;
    logic [UUID_W-1:0]   r_uuid;
    logic [NW_W-1:0]     r_wid;
    logic [NT-1:0]       r_tmask;
    logic [31:0]         r_pc;
    logic [1:0]          r_op;
    logic                r_use_imm;
    logic [4:0]          r_imm;
    logic [31:0]         r_rs1_data;
    logic [ADDR_W-1:0]   r_addr;
    logic [4:0]          r_rd;
    logic                r_wb;
    logic                r_wr_intent;
    logic [31:0]         r_old;

    logic                w_accept;
    logic                w_req_is_fp;
    logic                w_req_fpu_busy;
    logic                w_wid_fpu_busy;
    logic                w_req_wr_intent;
    logic [31:0]         w_src;
    logic [31:0]         w_wdata;

    // Request decode: FP-CSR hazard and whether the instruction writes at all.
    always_comb begin
        w_accept        = (r_state == ST_IDLE) && r_req_ready && bus.req_valid;
        w_req_is_fp     = (bus.req_addr == ADDR_W'(`CSR_FFLAGS))
                       || (bus.req_addr == ADDR_W'(`CSR_FRM))
                       || (bus.req_addr == ADDR_W'(`CSR_FCSR));
        w_req_fpu_busy  = w_req_is_fp && bus.fpu_pending[bus.req_wid];
        w_wid_fpu_busy  = bus.fpu_pending[r_wid];
        // RW always writes; set/clear only with a non-zero source operand
        w_req_wr_intent = (bus.req_op == 2'b01)
                       || (bus.req_use_imm ? (bus.req_imm != 5'd0) : !bus.req_rs1_zero);
`ifdef CSR_RO_GUARD_EN
        if (bus.req_addr[11:10] == 2'b11) begin
            w_req_wr_intent = 1'b0;
        end
`endif
    end

    // Modify step: new CSR value from the old value read this cycle.
    always_comb begin
        w_src   = r_use_imm ? {27'd0, r_imm} : r_rs1_data;
        w_wdata = 32'd0;
        case (r_op)
            2'b01:   w_wdata = w_src;
            2'b11:   w_wdata = bus.csr_read_data & ~w_src;
            default: w_wdata = bus.csr_read_data | w_src;
        endcase
    end

    // Sequencer: IDLE -> [STALL] -> ACCESS -> RSP, with registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_req_ready        <= 1'b0;
            r_busy             <= 1'b0;
            r_csr_read_enable  <= 1'b0;
            r_csr_write_enable <= 1'b0;
            r_rsp_valid        <= 1'b0;
            r_uuid             <= '0;
            r_wid              <= '0;
            r_tmask            <= '0;
            r_pc               <= '0;
            r_op               <= '0;
            r_use_imm          <= 1'b0;
            r_imm              <= '0;
            r_rs1_data         <= '0;
            r_addr             <= '0;
            r_rd               <= '0;
            r_wb               <= 1'b0;
            r_wr_intent        <= 1'b0;
            r_old              <= '0;
        end else begin
            r_csr_read_enable  <= 1'b0;
            r_csr_write_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // ready rises one cycle after reset release
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_uuid      <= bus.req_uuid;
                        r_wid       <= bus.req_wid;
                        r_tmask     <= bus.req_tmask;
                        r_pc        <= bus.req_pc;
                        r_op        <= bus.req_op;
                        r_use_imm   <= bus.req_use_imm;
                        r_imm       <= bus.req_imm;
                        r_rs1_data  <= bus.req_rs1_data;
                        r_addr      <= bus.req_addr;
                        r_rd        <= bus.req_rd;
                        r_wb        <= bus.req_wb;
                        r_wr_intent <= w_req_wr_intent;
                        if (w_req_fpu_busy) begin
                            r_state <= ST_STALL;
                        end else begin
                            r_state            <= ST_ACCESS;
                            r_csr_read_enable  <= 1'b1;
                            r_csr_write_enable <= w_req_wr_intent;
                        end
                    end
                end
                ST_STALL: begin
                    if (!w_wid_fpu_busy) begin
                        r_state            <= ST_ACCESS;
                        r_csr_read_enable  <= 1'b1;
                        r_csr_write_enable <= r_wr_intent;
                    end
                end
                ST_ACCESS: begin
                    r_old       <= bus.csr_read_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output drive: ports come straight from the latched request and strobes.
    assign bus.req_ready        = r_req_ready;
    assign bus.csr_busy         = r_busy;
    assign bus.csr_read_enable  = r_csr_read_enable;
    assign bus.csr_read_uuid    = r_uuid;
    assign bus.csr_read_addr    = r_addr;
    assign bus.csr_read_wid     = r_wid;
    assign bus.csr_write_enable = r_csr_write_enable;
    assign bus.csr_write_uuid   = r_uuid;
    assign bus.csr_write_addr   = r_addr;
    assign bus.csr_write_wid    = r_wid;
    // write data depends on the same-cycle read, so only valid during ACCESS
    assign bus.csr_write_data   = (r_state == ST_ACCESS) ? w_wdata : 32'd0;
    assign bus.rsp_valid        = r_rsp_valid;
    assign bus.rsp_uuid         = r_uuid;
    assign bus.rsp_wid          = r_wid;
    assign bus.rsp_tmask        = r_tmask;
    assign bus.rsp_pc           = r_pc;
    assign bus.rsp_rd           = r_rd;
    assign bus.rsp_wb           = r_wb;
    assign bus.rsp_data         = {NT{r_old}};

endmodule

// File: tb/tb_rv_csr_access_unit.sv
// tb_rv_csr_access_unit: directed table, reset and random transactions
// against a CSR data block model and a spec-level reference model.
`timescale 1ns/1ps

`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef CSR_FFLAGS
`define CSR_FFLAGS 12'h001
`endif
`ifndef CSR_FRM
`define CSR_FRM 12'h002
`endif
`ifndef CSR_FCSR
`define CSR_FCSR 12'h003
`endif
`ifndef CSR_MIE
`define CSR_MIE 12'h304
`endif
`ifndef CSR_MSCRATCH
`define CSR_MSCRATCH 12'h340
`endif
`ifndef CSR_MEPC
`define CSR_MEPC 12'h341
`endif
`ifndef CSR_MVENDORID
`define CSR_MVENDORID 12'hF11
`endif
`ifndef VENDOR_ID
`define VENDOR_ID 32'h0000_0B5A
`endif

module tb_rv_csr_access_unit;

    localparam int unsigned UUID_W = `UUID_BITS;
    localparam int unsigned NW_W   = `NW_BITS;
    localparam int unsigned NT     = `NUM_THREADS;
    localparam int unsigned NWARPS = `NUM_WARPS;
    localparam int unsigned ADDR_W = `CSR_ADDR_BITS;
`ifdef CSR_RO_GUARD_EN
    localparam bit RO_GUARD = 1'b1;
`else
    localparam bit RO_GUARD = 1'b0;
`endif

    typedef struct {
        logic [1:0]        op;
        logic              use_imm;
        logic [4:0]        imm;
        logic [31:0]       rs1;
        logic              rs1_zero;
        logic [ADDR_W-1:0] addr;
        logic [NW_W-1:0]   wid;
        logic [NWARPS-1:0] pend;
        int                pend_cyc;
        int                hold;
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [31:0] exp_old;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv_csr_access_unit_if u_if ();

    rv_csr_access_unit #(.CORE_ID(0)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (u_if.slave)
    );

    // CSR data block: combinational read, write at clock edge, RO space ignored.
    logic [31:0] csr_mem [4096];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'd0;
            csr_mem[`CSR_MEPC]      <= 32'h0000_00A5;
            csr_mem[`CSR_MIE]       <= 32'h0000_00F0;
            csr_mem[`CSR_FFLAGS]    <= 32'h0000_001F;
            csr_mem[`CSR_MVENDORID] <= `VENDOR_ID;
        end else if (u_if.csr_write_enable && u_if.csr_write_addr[11:10] != 2'b11) begin
            csr_mem[u_if.csr_write_addr] <= u_if.csr_write_data;
        end
    end
    assign u_if.csr_read_data = u_if.csr_read_enable ? csr_mem[u_if.csr_read_addr] : 32'd0;

    // Reference architectural CSR state.
    logic [31:0] model_csr [4096];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input string name,
                         input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    function automatic bit is_fp(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(`CSR_FFLAGS)) || (a == ADDR_W'(`CSR_FRM)) || (a == ADDR_W'(`CSR_FCSR));
    endfunction

    // CSR instruction semantics on the architectural state.
    task automatic model_exec(input txn_t t, output logic [31:0] old,
                              output logic we, output logic [31:0] nv);
        logic [31:0] src;
        old = model_csr[t.addr];
        src = t.use_imm ? {27'd0, t.imm} : t.rs1;
        we  = t.use_imm ? (t.imm != 5'd0) : !t.rs1_zero;
        case (t.op)
            2'b01:   begin nv = src; we = 1'b1; end
            2'b11:   nv = old & ~src;
            default: nv = old | src;
        endcase
        if (RO_GUARD && t.addr[11:10] == 2'b11) we = 1'b0;
    endtask

    task automatic model_commit(input txn_t t);
        logic [31:0] old, nv;
        logic we;
        model_exec(t, old, we, nv);
        if (we && t.addr[11:10] != 2'b11) model_csr[t.addr] = nv;
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                                input logic [31:0] rs1, input logic rs1_zero,
                                input logic [ADDR_W-1:0] addr, input int wid,
                                input logic [NWARPS-1:0] pend, input int pend_cyc, input int hold,
                                input logic [31:0] e_old, input logic e_we, input logic [31:0] e_wd);
        vec_t v;
        v.t.op = op; v.t.use_imm = use_imm; v.t.imm = imm; v.t.rs1 = rs1;
        v.t.rs1_zero = rs1_zero; v.t.addr = addr; v.t.wid = NW_W'(wid);
        v.t.pend = pend; v.t.pend_cyc = pend_cyc; v.t.hold = hold;
        v.exp_old = e_old; v.exp_we = e_we; v.exp_wd = e_wd;
        return v;
    endfunction

    task automatic junk_req();
        u_if.req_uuid     = UUID_W'($urandom);
        u_if.req_op       = 2'($urandom);
        u_if.req_addr     = ADDR_W'($urandom);
        u_if.req_rs1_data = $urandom;
        u_if.req_wid      = NW_W'($urandom);
    endtask

    // One full transaction; called and returning on a falling edge.
    task automatic run_txn(input txn_t t, input logic [31:0] e_old, input logic e_we,
                           input logic [31:0] e_wd, input string tag);
        logic [UUID_W-1:0] uuid;
        logic [NT-1:0]     tmask;
        logic [31:0]       pc, we_data;
        logic [4:0]        rd;
        logic              wb, busy_ok, stable_ok, port_ok;
        logic [255:0]      exp_fields, snap_fields;
        logic [NT*32-1:0]  snap_data;
        int acc_cyc, re_first, re_cnt, we_cnt, rsp_cyc, waited;

        uuid  = UUID_W'($urandom);
        tmask = NT'($urandom) | NT'(1);
        pc    = $urandom;
        rd    = 5'($urandom);
        wb    = 1'($urandom);
        exp_fields = 256'({uuid, t.wid, tmask, pc, rd, wb});
        acc_cyc = (is_fp(t.addr) && t.pend[t.wid]) ? t.pend_cyc + 1 : 1;

        u_if.req_uuid = uuid; u_if.req_wid = t.wid; u_if.req_tmask = tmask;
        u_if.req_pc = pc; u_if.req_op = t.op; u_if.req_use_imm = t.use_imm;
        u_if.req_imm = t.imm; u_if.req_rs1_data = t.rs1; u_if.req_rs1_zero = t.rs1_zero;
        u_if.req_addr = t.addr; u_if.req_rd = rd; u_if.req_wb = wb;
        u_if.fpu_pending = t.pend;
        u_if.req_valid = 1'b1;

        waited = 0;
        while (!u_if.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check(tag, "req_ready", 256'(u_if.req_ready), 256'(1));
        if (!u_if.req_ready) begin
            u_if.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        u_if.req_valid = 1'b0;
        junk_req();

        re_first = 0; re_cnt = 0; we_cnt = 0; we_data = 32'd0; rsp_cyc = 0;
        busy_ok = 1'b1; port_ok = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (t.pend != '0 && cyc == t.pend_cyc) u_if.fpu_pending = '0;
            if (u_if.csr_read_enable) begin
                re_cnt++;
                if (re_first == 0) re_first = cyc;
                if (u_if.csr_read_addr !== t.addr || u_if.csr_read_wid !== t.wid ||
                    u_if.csr_read_uuid !== uuid || u_if.csr_write_addr !== t.addr ||
                    u_if.csr_write_wid !== t.wid || u_if.csr_write_uuid !== uuid)
                    port_ok = 1'b0;
            end
            if (u_if.csr_write_enable) begin
                we_cnt++;
                we_data = u_if.csr_write_data;
            end
            if (!u_if.csr_busy || u_if.req_ready) busy_ok = 1'b0;
            if (u_if.rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        u_if.fpu_pending = '0;

        check(tag, "access_cycle", 256'(re_first), 256'(acc_cyc));
        check(tag, "read_enable_count", 256'(re_cnt), 256'(1));
        check(tag, "write_enable_count", 256'(we_cnt), 256'(e_we ? 1 : 0));
        if (e_we) check(tag, "write_data", 256'(we_data), 256'(e_wd));
        check(tag, "csr_port_fields", 256'(port_ok), 256'(1));
        check(tag, "busy_during_op", 256'(busy_ok), 256'(1));
        check(tag, "rsp_cycle", 256'(rsp_cyc), 256'(acc_cyc + 1));
        if (rsp_cyc == 0) return;
        check(tag, "rsp_data", 256'(u_if.rsp_data), 256'({NT{e_old}}));
        snap_fields = 256'({u_if.rsp_uuid, u_if.rsp_wid, u_if.rsp_tmask,
                            u_if.rsp_pc, u_if.rsp_rd, u_if.rsp_wb});
        check(tag, "rsp_fields", snap_fields, exp_fields);

        snap_data = u_if.rsp_data;
        stable_ok = 1'b1;
        for (int h = 0; h < t.hold; h++) begin
            u_if.rsp_ready = 1'b0;
            u_if.req_valid = 1'b1;
            junk_req();
            @(negedge clk);
            if (!u_if.rsp_valid || u_if.rsp_data !== snap_data || u_if.req_ready ||
                !u_if.csr_busy || u_if.csr_read_enable || u_if.csr_write_enable ||
                256'({u_if.rsp_uuid, u_if.rsp_wid, u_if.rsp_tmask, u_if.rsp_pc,
                      u_if.rsp_rd, u_if.rsp_wb}) !== snap_fields)
                stable_ok = 1'b0;
        end
        if (t.hold > 0) check(tag, "rsp_hold_stable", 256'(stable_ok), 256'(1));
        u_if.req_valid = 1'b0;
        u_if.rsp_ready = 1'b1;
        @(negedge clk);
        u_if.rsp_ready = 1'b0;
        check(tag, "after_rsp{valid,ready,busy}",
              256'({u_if.rsp_valid, u_if.req_ready, u_if.csr_busy}), 256'(3'b010));
    endtask

    vec_t vecs[13];
    logic [ADDR_W-1:0] addr_list[7];

    initial begin
        txn_t t;
        logic [31:0] m_old, m_wd;
        logic m_we;

        u_if.req_valid = 1'b0; u_if.rsp_ready = 1'b0; u_if.fpu_pending = '0;
        u_if.req_uuid = '0; u_if.req_wid = '0; u_if.req_tmask = '0; u_if.req_pc = '0;
        u_if.req_op = '0; u_if.req_use_imm = 1'b0; u_if.req_imm = '0;
        u_if.req_rs1_data = '0; u_if.req_rs1_zero = 1'b0; u_if.req_addr = '0;
        u_if.req_rd = '0; u_if.req_wb = 1'b0;

        for (int i = 0; i < 4096; i++) model_csr[i] = 32'd0;
        model_csr[`CSR_MEPC]      = 32'h0000_00A5;
        model_csr[`CSR_MIE]       = 32'h0000_00F0;
        model_csr[`CSR_FFLAGS]    = 32'h0000_001F;
        model_csr[`CSR_MVENDORID] = `VENDOR_ID;

        //            op    imm? imm    rs1           rs1z  addr            wid pend   pc hold old            we          wdata
        vecs[0]  = mk(2'b01, 0, 5'd0,  32'h0000_1234, 0, `CSR_MEPC,      0, 4'h0, 0, 0, 32'h0000_00A5, 1'b1,       32'h0000_1234);
        vecs[1]  = mk(2'b10, 0, 5'd0,  32'h0000_0000, 1, `CSR_MEPC,      0, 4'h0, 0, 0, 32'h0000_1234, 1'b0,       32'h0000_1234);
        vecs[2]  = mk(2'b10, 0, 5'd0,  32'h0000_000F, 0, `CSR_MIE,       1, 4'h0, 0, 0, 32'h0000_00F0, 1'b1,       32'h0000_00FF);
        vecs[3]  = mk(2'b10, 0, 5'd0,  32'h0000_0000, 1, `CSR_MIE,       2, 4'h0, 0, 0, 32'h0000_00FF, 1'b0,       32'h0000_00FF);
        vecs[4]  = mk(2'b11, 1, 5'd1,  32'h0000_0000, 0, `CSR_FFLAGS,    1, 4'h2, 4, 0, 32'h0000_001F, 1'b1,       32'h0000_001E);
        vecs[5]  = mk(2'b10, 0, 5'd0,  32'h0000_0000, 1, `CSR_FFLAGS,    0, 4'h4, 3, 0, 32'h0000_001E, 1'b0,       32'h0000_001E);
        vecs[6]  = mk(2'b01, 0, 5'd0,  32'h0000_DEAD, 0, `CSR_MVENDORID, 3, 4'h0, 0, 5, `VENDOR_ID,    !RO_GUARD,  32'h0000_DEAD);
        vecs[7]  = mk(2'b00, 1, 5'd0,  32'h0000_FFFF, 0, `CSR_MIE,       0, 4'h0, 0, 0, 32'h0000_00FF, 1'b0,       32'h0000_00FF);
        vecs[8]  = mk(2'b11, 0, 5'd0,  32'h0000_0034, 0, `CSR_MEPC,      2, 4'h0, 0, 1, 32'h0000_1234, 1'b1,       32'h0000_1200);
        vecs[9]  = mk(2'b01, 1, 5'd0,  32'h0000_0000, 0, `CSR_MSCRATCH,  1, 4'h0, 0, 0, 32'h0000_0000, 1'b1,       32'h0000_0000);
        vecs[10] = mk(2'b10, 1, 5'd5,  32'h0000_0000, 0, `CSR_MSCRATCH,  1, 4'h0, 0, 0, 32'h0000_0000, 1'b1,       32'h0000_0005);
        vecs[11] = mk(2'b11, 0, 5'd0,  32'h0000_0004, 0, `CSR_MSCRATCH,  0, 4'h0, 0, 2, 32'h0000_0005, 1'b1,       32'h0000_0001);
        vecs[12] = mk(2'b01, 0, 5'd0,  32'h0000_00E0, 0, `CSR_FCSR,      3, 4'h8, 1, 0, 32'h0000_0000, 1'b1,       32'h0000_00E0);

        addr_list[0] = `CSR_FFLAGS; addr_list[1] = `CSR_FRM;  addr_list[2] = `CSR_FCSR;
        addr_list[3] = `CSR_MIE;    addr_list[4] = `CSR_MEPC; addr_list[5] = `CSR_MSCRATCH;
        addr_list[6] = `CSR_MVENDORID;

        // reset: data block preload, all outputs low, ready after release
        preload = 1'b1;
        @(negedge clk); @(negedge clk);
        preload = 1'b0;
        check("reset", "ctrl_outputs",
              256'({u_if.req_ready, u_if.csr_busy, u_if.csr_read_enable,
                    u_if.csr_write_enable, u_if.rsp_valid}), 256'(0));
        check("reset", "data_outputs",
              256'({u_if.rsp_data, u_if.csr_read_addr, u_if.rsp_pc, u_if.csr_write_data}), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset", "ready_after_release", 256'(u_if.req_ready), 256'(1));

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].t, vecs[i].exp_old, vecs[i].exp_we, vecs[i].exp_wd,
                    $sformatf("vec%0d", i));
            model_commit(vecs[i].t);
        end

        // reset while stalled on an FP CSR: request dropped, no write
        u_if.req_uuid = UUID_W'(7); u_if.req_wid = NW_W'(2); u_if.req_tmask = '1;
        u_if.req_pc = 32'h100; u_if.req_op = 2'b01; u_if.req_use_imm = 1'b0;
        u_if.req_imm = '0; u_if.req_rs1_data = 32'hAA; u_if.req_rs1_zero = 1'b0;
        u_if.req_addr = `CSR_FFLAGS; u_if.req_rd = 5'd3; u_if.req_wb = 1'b1;
        u_if.fpu_pending = NWARPS'(4);
        u_if.req_valid = 1'b1;
        @(negedge clk);
        u_if.req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_stall", "stalled{busy,re}",
              256'({u_if.csr_busy, u_if.csr_read_enable}), 256'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check("rst_stall", "ctrl_outputs",
              256'({u_if.req_ready, u_if.csr_busy, u_if.csr_read_enable,
                    u_if.csr_write_enable, u_if.rsp_valid}), 256'(0));
        check("rst_stall", "data_outputs",
              256'({u_if.rsp_data, u_if.csr_read_addr, u_if.rsp_pc, u_if.csr_write_data}), 256'(0));
        u_if.fpu_pending = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall", "fflags_unwritten", 256'(csr_mem[`CSR_FFLAGS]), 256'(model_csr[`CSR_FFLAGS]));
        t = vecs[5].t;
        t.pend = '0;
        model_exec(t, m_old, m_we, m_wd);
        run_txn(t, m_old, m_we, m_wd, "rst_fresh");
        model_commit(t);

        // random transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            t.op       = 2'($urandom);
            t.use_imm  = 1'($urandom);
            t.imm      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            t.rs1_zero = ($urandom_range(0, 3) == 0);
            t.rs1      = t.rs1_zero ? 32'd0 : $urandom;
            t.addr     = addr_list[$urandom_range(0, 6)];
            t.wid      = NW_W'($urandom);
            t.pend     = ($urandom_range(0, 1) == 1) ? NWARPS'($urandom) : '0;
            t.pend_cyc = $urandom_range(1, 4);
            t.hold     = $urandom_range(0, 3);
            model_exec(t, m_old, m_we, m_wd);
            run_txn(t, m_old, m_we, m_wd, $sformatf("rnd%0d", n));
            model_commit(t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
